hls_deadlock_channel_monitor: RTL



---
 rtl/hls_deadlock_pkg.sv | 20 ++
 rtl/hls_deadlock_channel_monitor_if.sv | 31 +++
 rtl/hls_deadlock_prio_enc.sv | 27 ++
 rtl/hls_deadlock_channel_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hls_deadlock_pkg.sv
// Shared types and constants for the HLS kernel deadlock channel monitor.
package hls_deadlock_pkg;

   // Detection FSM states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WATCH     = 2'd1,
      ST_CONFIRMED = 2'd2
   } dl_state_e;

   // Confirmed-event counter width and saturation value
   localparam int         EVT_W   = 8;
   localparam logic [7:0] EVT_MAX = 8'd255;

   // Index width for a vector of n channels, never narrower than one bit
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hls_deadlock_channel_monitor_if.sv
// Monitor-facing bundle: block/idle flags in, detection results out.
interface hls_deadlock_channel_monitor_if #(
   parameter int NUM_AXIS = 4,
   parameter int NUM_INST = 2,
   parameter int CNT_W    = 16,
   parameter int IDX_W    = hls_deadlock_pkg::idx_width(NUM_AXIS)
);
   logic                               i_enable;
   logic                               i_clear;
   logic [NUM_AXIS-1:0]                i_axis_block_sigs;
   logic [NUM_INST-1:0]                i_inst_idle_sigs;
   logic [NUM_INST-1:0]                i_inst_block_sigs;
   logic                               o_block;
   logic                               o_deadlock;
   logic [CNT_W-1:0]                   o_block_cnt;
   logic [IDX_W-1:0]                   o_first_chan;
   logic                               o_first_is_inst;
   logic [hls_deadlock_pkg::EVT_W-1:0] o_event_count;

   // Kernel / bench side: drives the flags, observes the results
   modport master (
      output i_enable, i_clear, i_axis_block_sigs, i_inst_idle_sigs, i_inst_block_sigs,
      input  o_block, o_deadlock, o_block_cnt, o_first_chan, o_first_is_inst, o_event_count
   );

   // Monitor side
   modport slave (
      input  i_enable, i_clear, i_axis_block_sigs, i_inst_idle_sigs, i_inst_block_sigs,
      output o_block, o_deadlock, o_block_cnt, o_first_chan, o_first_is_inst, o_event_count
   );
endinterface

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted bit plus a found flag.
module hls_deadlock_prio_enc
   import hls_deadlock_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     i_vec,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_found
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = IDX_W'(i);
            o_found = 1'b1;
         end else begin
            o_found = o_found;
         end
      end
   end

endmodule

// File: rtl/hls_deadlock_channel_monitor.sv
// Deadlock monitor for one HLS kernel instance: a qualified block must persist
// THRESHOLD consecutive cycles before a deadlock is declared. Records which
// channel started the episode and counts confirmed deadlocks (saturating).
module hls_deadlock_channel_monitor
   import hls_deadlock_pkg::*;
#(
   parameter int NUM_AXIS  = 4,
   parameter int NUM_INST  = 2,
   parameter int CNT_W     = 16,
   parameter int THRESHOLD = 1024,
   parameter int STICKY    = 1,
   parameter int IDX_W     = idx_width(NUM_AXIS)
) (
   input logic                     clock,
   input logic                     reset,
   hls_deadlock_channel_monitor_if.slave mon
);

   localparam logic [CNT_W-1:0] TH_C = CNT_W'(THRESHOLD);

   logic             w_qb;
   logic [IDX_W-1:0] w_first_idx;
   logic             w_axis_found;

   dl_state_e        r_state;
   dl_state_e        w_state_nxt;
   logic             r_block;
   logic             r_deadlock;
   logic             w_deadlock_nxt;
   logic [CNT_W-1:0] r_block_cnt;
   logic [CNT_W-1:0] w_block_cnt_nxt;
   logic [IDX_W-1:0] r_first_chan;
   logic [IDX_W-1:0] w_first_chan_nxt;
   logic             r_first_is_inst;
   logic             w_first_is_inst_nxt;
   logic [EVT_W-1:0] r_event_count;
   logic             w_confirm;

   // A block only counts while enabled and while at least one instance is busy
   assign w_qb = mon.i_enable & ~(&mon.i_inst_idle_sigs) &
                 ((|mon.i_axis_block_sigs) | (|mon.i_inst_block_sigs));

   hls_deadlock_prio_enc #(
      .N     (NUM_AXIS),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .i_vec   (mon.i_axis_block_sigs),
      .o_idx   (w_first_idx),
      .o_found (w_axis_found)
   );

   // Registered qualified block; follows qb regardless of FSM state or clear
   always_ff @(posedge clock) begin
      if (reset) r_block <= 1'b0;
      else       r_block <= w_qb;
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and detection datapath; clear overrides any FSM activity
   always_comb begin
      w_state_nxt         = r_state;
      w_block_cnt_nxt     = r_block_cnt;
      w_deadlock_nxt      = r_deadlock;
      w_first_chan_nxt    = r_first_chan;
      w_first_is_inst_nxt = r_first_is_inst;
      w_confirm           = 1'b0;
      if (mon.i_clear) begin
         w_state_nxt         = ST_IDLE;
         w_block_cnt_nxt     = '0;
         w_deadlock_nxt      = 1'b0;
         w_first_chan_nxt    = '0;
         w_first_is_inst_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_qb) begin
                  w_first_chan_nxt    = w_first_idx;
                  w_first_is_inst_nxt = ~w_axis_found;
                  w_block_cnt_nxt     = CNT_W'(1);
                  if (THRESHOLD == 1) begin
                     w_state_nxt    = ST_CONFIRMED;
                     w_deadlock_nxt = 1'b1;
                     w_confirm      = 1'b1;
                  end else begin
                     w_state_nxt = ST_WATCH;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_WATCH: begin
               if (w_qb) begin
                  if (r_block_cnt == (TH_C - CNT_W'(1))) begin
                     w_block_cnt_nxt = TH_C;
                     w_state_nxt     = ST_CONFIRMED;
                     w_deadlock_nxt  = 1'b1;
                     w_confirm       = 1'b1;
                  end else begin
                     w_block_cnt_nxt = r_block_cnt + CNT_W'(1);
                  end
               end else begin
                  // Episode ended early; first_chan/first_is_inst stay for debug
                  w_state_nxt     = ST_IDLE;
                  w_block_cnt_nxt = '0;
               end
            end
            ST_CONFIRMED: begin
               if ((STICKY == 0) && !w_qb) begin
                  w_state_nxt     = ST_IDLE;
                  w_deadlock_nxt  = 1'b0;
                  w_block_cnt_nxt = '0;
               end else begin
                  w_state_nxt = ST_CONFIRMED;
               end
            end
            default: begin
               w_state_nxt     = ST_IDLE;
               w_block_cnt_nxt = '0;
               w_deadlock_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Detection result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_block_cnt     <= '0;
         r_deadlock      <= 1'b0;
         r_first_chan    <= '0;
         r_first_is_inst <= 1'b0;
      end else begin
         r_block_cnt     <= w_block_cnt_nxt;
         r_deadlock      <= w_deadlock_nxt;
         r_first_chan    <= w_first_chan_nxt;
         r_first_is_inst <= w_first_is_inst_nxt;
      end
   end

   // Confirmed-event counter; survives clear, saturates instead of wrapping
   always_ff @(posedge clock) begin
      if (reset)                                    r_event_count <= '0;
      else if (w_confirm && (r_event_count != EVT_MAX)) r_event_count <= r_event_count + 8'd1;
      else                                          r_event_count <= r_event_count;
   end

   assign mon.o_block         = r_block;
   assign mon.o_deadlock      = r_deadlock;
   assign mon.o_block_cnt     = r_block_cnt;
   assign mon.o_first_chan    = r_first_chan;
   assign mon.o_first_is_inst = r_first_is_inst;
   assign mon.o_event_count   = r_event_count;

endmodule
